// File: rtl/cook_ctrl_fsm.sv
// Microwave cook controller: edge-detected keys, pause/resume, end-of-cook beep
// and PWM power gating of the magnetron, with legacy S/R timer outputs.
module cook_ctrl_fsm #(
    parameter int PWR_W       = 3,
    parameter int BEEP_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startn,
    input  logic             stopn,
    input  logic             clearn,
    input  logic             door_closed,
    input  logic             timer_done,
    input  logic [PWR_W-1:0] power_level,
    output logic             S,
    output logic             R,
    output logic             timer_clear,
    output logic             mag_on,
    output logic             beep,
    output logic             lamp,
    output logic [1:0]       state
);

    localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam logic [BW-1:0]    BEEP_LAST = BW'(BEEP_CYCLES - 1);
    localparam logic [PWR_W-1:0] PWM_MAX   = ~PWR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COOK  = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic             startn_q, stopn_q;
    logic [PWR_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWR_W-1:0] pwr_lat_q, pwr_lat_d;
    logic [BW-1:0]    beep_cnt_q, beep_cnt_d;
    logic             tclr_q, tclr_d;
    logic             s_q, beep_q;

    logic start_ev, stop_ev, clear;

    assign start_ev = startn_q & ~startn;
    assign stop_ev  = stopn_q & ~stopn;
    assign clear    = ~clearn;

    always_comb begin
        state_d    = state_q;
        pwm_cnt_d  = pwm_cnt_q;
        pwr_lat_d  = pwr_lat_q;
        beep_cnt_d = beep_cnt_q;
        tclr_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    tclr_d = 1'b1;
                end else if (start_ev & door_closed & ~timer_done) begin
                    state_d   = COOK;
                    pwr_lat_d = power_level;
                    pwm_cnt_d = '0;
                end
            end
            COOK: begin
                pwm_cnt_d = (pwm_cnt_q == PWM_MAX) ? '0 : pwm_cnt_q + 1'b1;
                if (clear) begin
                    state_d = IDLE;
                    tclr_d  = 1'b1;
                end else if (~door_closed | stop_ev) begin
                    state_d = PAUSE;
                end else if (timer_done) begin
                    state_d    = DONE;
                    beep_cnt_d = '0;
                end
            end
            PAUSE: begin
                // a second stop while paused cancels the cook
                if (clear | stop_ev) begin
                    state_d = IDLE;
                    tclr_d  = 1'b1;
                end else if (start_ev & door_closed) begin
                    state_d   = COOK;
                    pwr_lat_d = power_level;
                    pwm_cnt_d = '0;
                end
            end
            DONE: begin
                if (clear | stop_ev | ~door_closed) begin
                    state_d = IDLE;
                end else if (beep_cnt_q == BEEP_LAST) begin
                    state_d = IDLE;
                end else begin
                    beep_cnt_d = beep_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            startn_q   <= 1'b1;
            stopn_q    <= 1'b1;
            pwm_cnt_q  <= '0;
            pwr_lat_q  <= '0;
            beep_cnt_q <= '0;
            tclr_q     <= 1'b0;
            s_q        <= 1'b0;
            beep_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            startn_q   <= startn;
            stopn_q    <= stopn;
            pwm_cnt_q  <= pwm_cnt_d;
            pwr_lat_q  <= pwr_lat_d;
            beep_cnt_q <= beep_cnt_d;
            tclr_q     <= tclr_d;
            s_q        <= (state_d == COOK);
            beep_q     <= (state_d == DONE);
        end
    end

    // door and reset gate the magnetron without waiting for a clock edge
    assign mag_on = (state_q == COOK) & door_closed & ~rst
                  & (pwm_cnt_q < pwr_lat_q);

    assign S           = s_q;
    assign R           = ~s_q;
    assign timer_clear = tclr_q;
    assign beep        = beep_q;
    assign lamp        = (state_q != IDLE) | ~door_closed;
    assign state       = state_q;

endmodule
